// File: rtl/i2c_flash_page_bridge.sv
// i2c_flash_page_bridge
//   I2C slave bridging byte transactions onto an SST-style parallel flash.
//   Bit timing runs on SCL rising edges; START/STOP arrive as decoded
//   one-cycle strobes. Write data is collected in a page buffer and
//   programmed after STOP using the 5555/2AAA unlock sequence. Reads are
//   sequential with address auto-increment.
// Ports
//   SCL, RESET        clock (rising edge) / async active-high reset
//   START, STOP       decoded bus condition strobes
//   din               sampled SDA
//   SDAOut, EnSDAOut  SDA drive value / enable (ACK = enabled low)
//   Addr, IOOut, IOIn flash address, write data, read data
//   EnIOOut           flash IO bus drive enable
//   ENbar/WEbar/REbar flash chip/write/read enables, active low
//   Busy              flush in progress
//   Level             bytes currently buffered
module i2c_flash_page_bridge #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned ADDR_BYTES  = 2,
  parameter logic [6:0]  DEV_ID      = 7'h50,
  parameter int unsigned PAGE_DEPTH  = 16,
  parameter int unsigned PROG_CYCLES = 8
) (
  input  logic                          SCL,
  input  logic                          RESET,
  input  logic                          START,
  input  logic                          STOP,
  input  logic                          din,
  output logic                          SDAOut,
  output logic                          EnSDAOut,
  output logic [ADDR_W-1:0]             Addr,
  output logic [7:0]                    IOOut,
  input  logic [7:0]                    IOIn,
  output logic                          EnIOOut,
  output logic                          ENbar,
  output logic                          WEbar,
  output logic                          REbar,
  output logic                          Busy,
  output logic [$clog2(PAGE_DEPTH):0]   Level
);

  localparam int unsigned PTR_W  = $clog2(PAGE_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned ABC_W  = $clog2(ADDR_BYTES + 1);
  localparam int unsigned WAIT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, DEVID, DEVACK, ADDR, ADDRACK, WDATA, WACK, RDATA, RACK, FL_CMD, FL_WAIT
  } stateT;

  stateT state, stateNext;

  logic [2:0]        bitCnt;
  logic [7:0]        shiftReg;
  logic              ackOk;
  logic              isRead;
  logic [ADDR_W-1:0] addrAcc;
  logic [ADDR_W-1:0] addrPtr;
  logic [ABC_W-1:0]  addrByteCnt;
  logic [LVL_W-1:0]  flIdx;
  logic [1:0]        wrIdx;
  logic              wrPhase;
  logic [WAIT_W-1:0] waitCnt;
  logic [7:0]        pageBuf [PAGE_DEPTH];

  logic [7:0] rxByte;
  logic       byteDone;
  logic       flushing;
  logic       bufFull;
  logic       bufWe;
  logic       lastByte;
  logic       waitDone;

  assign rxByte   = {shiftReg[6:0], din};
  assign byteDone = (bitCnt == 3'd7);
  assign flushing = (state == FL_CMD) || (state == FL_WAIT);
  assign bufFull  = (Level == LVL_W'(PAGE_DEPTH));
  assign lastByte = (flIdx == Level - 1'b1);
  assign waitDone = (waitCnt == WAIT_W'(PROG_CYCLES - 1));
  // START/STOP take priority over the bit in flight, so a byte completing
  // in the same cycle as either strobe is never stored.
  assign bufWe    = (state == WDATA) && !STOP && !START && byteDone && !bufFull;

  always_ff @(posedge SCL or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (flushing) begin
      // Bus conditions are ignored while flushing; the slave never drives
      // SDA here, so any device ID is implicitly NACKed.
      if (state == FL_CMD) begin
        if (wrIdx == 2'd3 && wrPhase) stateNext = FL_WAIT;
      end else if (waitDone) begin
        stateNext = lastByte ? IDLE : FL_CMD;
      end
    end else if (STOP) begin
      stateNext = (Level != '0) ? FL_CMD : IDLE;
    end else if (START) begin
      stateNext = DEVID;
    end else begin
      unique case (state)
        DEVID:   if (byteDone) stateNext = DEVACK;
        DEVACK:  stateNext = !ackOk ? IDLE : (isRead ? RDATA : ADDR);
        ADDR:    if (byteDone) stateNext = ADDRACK;
        ADDRACK: stateNext = (addrByteCnt == ABC_W'(ADDR_BYTES)) ? WDATA : ADDR;
        WDATA:   if (byteDone) stateNext = WACK;
        WACK:    stateNext = WDATA;
        RDATA:   if (byteDone) stateNext = RACK;
        RACK:    stateNext = din ? IDLE : RDATA;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    SDAOut   = 1'b0;
    EnSDAOut = 1'b0;
    Addr     = '0;
    IOOut    = '0;
    EnIOOut  = 1'b0;
    ENbar    = 1'b1;
    WEbar    = 1'b1;
    REbar    = 1'b1;
    Busy     = 1'b0;
    unique case (state)
      DEVACK: begin
        EnSDAOut = ackOk;
        if (ackOk && isRead) begin
          ENbar = 1'b0;
          REbar = 1'b0;
          Addr  = addrPtr;
        end
      end
      ADDRACK, WACK: EnSDAOut = ackOk;
      RDATA: begin
        EnSDAOut = 1'b1;
        SDAOut   = shiftReg[7];
      end
      RACK: begin
        // Fetch only when the master is ACKing, so a final NACK leaves no
        // stray read strobe on the flash.
        if (!din) begin
          ENbar = 1'b0;
          REbar = 1'b0;
          Addr  = addrPtr;
        end
      end
      FL_CMD: begin
        Busy    = 1'b1;
        ENbar   = 1'b0;
        EnIOOut = 1'b1;
        WEbar   = wrPhase;
        unique case (wrIdx)
          2'd0: begin Addr = ADDR_W'(16'h5555); IOOut = 8'hAA; end
          2'd1: begin Addr = ADDR_W'(16'h2AAA); IOOut = 8'h55; end
          2'd2: begin Addr = ADDR_W'(16'h5555); IOOut = 8'hA0; end
          default: begin
            Addr  = addrPtr + ADDR_W'(flIdx);
            IOOut = pageBuf[flIdx[PTR_W-1:0]];
          end
        endcase
      end
      FL_WAIT: Busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge SCL) begin
    if (bufWe) pageBuf[Level[PTR_W-1:0]] <= rxByte;
  end

  always_ff @(posedge SCL or posedge RESET) begin
    if (RESET) begin
      bitCnt      <= '0;
      shiftReg    <= '0;
      ackOk       <= 1'b0;
      isRead      <= 1'b0;
      addrAcc     <= '0;
      addrPtr     <= '0;
      addrByteCnt <= '0;
      Level       <= '0;
      flIdx       <= '0;
      wrIdx       <= '0;
      wrPhase     <= 1'b0;
      waitCnt     <= '0;
    end else if (state == FL_CMD) begin
      wrPhase <= !wrPhase;
      if (wrPhase) wrIdx <= wrIdx + 1'b1;
      waitCnt <= '0;
    end else if (state == FL_WAIT) begin
      if (waitDone) begin
        waitCnt <= '0;
        if (lastByte) begin
          Level   <= '0;
          addrPtr <= addrPtr + ADDR_W'(Level);
          flIdx   <= '0;
        end else begin
          flIdx <= flIdx + 1'b1;
        end
      end else begin
        waitCnt <= waitCnt + 1'b1;
      end
    end else if (STOP) begin
      bitCnt  <= '0;
      flIdx   <= '0;
      wrIdx   <= '0;
      wrPhase <= 1'b0;
      waitCnt <= '0;
    end else if (START) begin
      bitCnt <= '0;
    end else begin
      unique case (state)
        DEVID: begin
          shiftReg <= rxByte;
          bitCnt   <= bitCnt + 1'b1;
          if (byteDone) begin
            isRead <= din;
            ackOk  <= (shiftReg[6:0] == DEV_ID) && (!din || Level == '0);
          end
        end
        DEVACK: begin
          bitCnt      <= '0;
          addrByteCnt <= '0;
          if (ackOk && isRead) begin
            shiftReg <= IOIn;
            addrPtr  <= addrPtr + 1'b1;
          end
        end
        ADDR: begin
          shiftReg <= rxByte;
          bitCnt   <= bitCnt + 1'b1;
          if (byteDone) begin
            addrAcc     <= ADDR_W'({addrAcc, rxByte});
            addrByteCnt <= addrByteCnt + 1'b1;
            ackOk       <= 1'b1;
          end
        end
        ADDRACK: begin
          bitCnt <= '0;
          if (addrByteCnt == ABC_W'(ADDR_BYTES)) addrPtr <= addrAcc;
        end
        WDATA: begin
          shiftReg <= rxByte;
          bitCnt   <= bitCnt + 1'b1;
          if (byteDone) begin
            ackOk <= !bufFull;
            if (!bufFull) Level <= Level + 1'b1;
          end
        end
        RDATA: begin
          shiftReg <= {shiftReg[6:0], 1'b0};
          bitCnt   <= bitCnt + 1'b1;
        end
        RACK: begin
          bitCnt <= '0;
          if (!din) begin
            shiftReg <= IOIn;
            addrPtr  <= addrPtr + 1'b1;
          end
        end
        default: bitCnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_flash_page_bridge.sv
// Bench for i2c_flash_page_bridge: drives I2C bit cycles, models the flash
// read data, and scoreboards expected flash writes/read addresses.
module tb_i2c_flash_page_bridge;

  localparam int PROG = 8;

  logic        SCL = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        din = 1'b1;
  logic        SDAOut, EnSDAOut, EnIOOut, ENbar, WEbar, REbar, Busy;
  logic [15:0] Addr;
  logic [7:0]  IOOut, IOIn;
  logic [4:0]  Level;

  i2c_flash_page_bridge #(
    .ADDR_W(16), .ADDR_BYTES(2), .DEV_ID(7'h50), .PAGE_DEPTH(16), .PROG_CYCLES(PROG)
  ) dut (
    .SCL(SCL), .RESET(RESET), .START(START), .STOP(STOP), .din(din),
    .SDAOut(SDAOut), .EnSDAOut(EnSDAOut), .Addr(Addr), .IOOut(IOOut), .IOIn(IOIn),
    .EnIOOut(EnIOOut), .ENbar(ENbar), .WEbar(WEbar), .REbar(REbar),
    .Busy(Busy), .Level(Level)
  );

  always #5 SCL = ~SCL;

  function automatic logic [7:0] flashByte(input logic [15:0] a);
    case (a)
      16'hFFFE: return 8'h5A;
      16'hFFFF: return 8'h6B;
      16'h0000: return 8'h7C;
      default:  return a[7:0] ^ 8'h3C;
    endcase
  endfunction

  assign IOIn = flashByte(Addr);

  int          tests = 0;
  int          failed = 0;
  int          busyCnt = 0;
  logic        obsSda, obsEn, obsBusy;
  logic [23:0] wrQ [$];
  logic [15:0] rdQ [$];
  logic [7:0]  rdDataQ [$];
  logic [7:0]  txData [32];

  // One SCL cycle: inputs applied after the rising edge, outputs sampled on
  // the falling edge, flash strobes scoreboarded as they appear.
  task automatic step(input logic d, input logic s, input logic p);
    logic [23:0] e24;
    logic [15:0] e16;
    din = d; START = s; STOP = p;
    @(negedge SCL);
    obsSda = SDAOut; obsEn = EnSDAOut; obsBusy = Busy;
    if (Busy) busyCnt++;
    if (!ENbar && !WEbar) begin
      tests++;
      if (wrQ.size() == 0) begin
        failed++;
        $display("FAIL flash_write_unexpected: got addr %h data %h, required no write", Addr, IOOut);
      end else begin
        e24 = wrQ.pop_front();
        if ({Addr, IOOut} !== e24 || EnIOOut !== 1'b1) begin
          failed++;
          $display("FAIL flash_write: got addr %h data %h en %b, required addr %h data %h en 1",
                   Addr, IOOut, EnIOOut, e24[23:8], e24[7:0]);
        end
      end
    end
    if (!ENbar && !REbar) begin
      tests++;
      if (rdQ.size() == 0) begin
        failed++;
        $display("FAIL flash_read_unexpected: got addr %h, required no read", Addr);
      end else begin
        e16 = rdQ.pop_front();
        if (Addr !== e16) begin
          failed++;
          $display("FAIL flash_read_addr: got %h, required %h", Addr, e16);
        end
      end
    end
    @(posedge SCL);
    #1;
    START = 1'b0; STOP = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) step(b[i], 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    acked = obsEn && !obsSda;
  endtask

  task automatic readByte(input logic nack, output logic [7:0] b, output logic allEn);
    b = '0;
    allEn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0);
      b = {b[6:0], obsSda};
      allEn = allEn & obsEn;
    end
    step(nack, 1'b0, 1'b0);
  endtask

  // START, write ID, address, then n data bytes from txData (no STOP).
  task automatic writeTxn(input logic [15:0] a, input int n, output logic [31:0] acks);
    logic k;
    acks = '0;
    step(1'b1, 1'b1, 1'b0);
    sendByte(8'hA0, k); acks[0] = k;
    sendByte(a[15:8], k); acks[1] = k;
    sendByte(a[7:0], k); acks[2] = k;
    for (int i = 0; i < n; i++) begin
      sendByte(txData[i], k);
      acks[3+i] = k;
    end
  endtask

  task automatic pushProgram(input logic [15:0] base, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      wrQ.push_back({16'h5555, 8'hAA});
      wrQ.push_back({16'h2AAA, 8'h55});
      wrQ.push_back({16'h5555, 8'hA0});
      wrQ.push_back({a, txData[i]});
    end
  endtask

  task automatic waitIdle(input int budget, output logic timedOut);
    int n;
    n = 0;
    do begin
      step(1'b1, 1'b0, 1'b0);
      n++;
    end while (obsBusy && n < budget);
    timedOut = obsBusy;
  endtask

  task automatic test_reset;
    #12;
    tests++;
    if ({ENbar, WEbar, REbar} !== 3'b111) begin
      failed++; $display("FAIL reset_strobes: got %b, required 111", {ENbar, WEbar, REbar});
    end
    tests++;
    if ({Busy, EnSDAOut, EnIOOut, Level} !== 8'h00) begin
      failed++; $display("FAIL reset_outputs: got busy %b ensda %b enio %b level %0d, required all 0",
                         Busy, EnSDAOut, EnIOOut, Level);
    end
    RESET = 1'b0;
  endtask

  task automatic test_write_two;
    logic [31:0] acks;
    logic        to;
    logic [7:0]  b;
    logic        en;
    txData[0] = 8'h11; txData[1] = 8'h22;
    writeTxn(16'h1234, 2, acks);
    tests++;
    if (acks[4:0] !== 5'b11111) begin
      failed++; $display("FAIL write2_acks: got %b, required 11111", acks[4:0]);
    end
    tests++;
    if (Level !== 5'd2) begin
      failed++; $display("FAIL write2_level: got %0d, required 2", Level);
    end
    pushProgram(16'h1234, 2);
    busyCnt = 0;
    step(1'b1, 1'b0, 1'b1);
    waitIdle(200, to);
    tests++;
    if (to || busyCnt != 2 * (8 + PROG)) begin
      failed++; $display("FAIL write2_busy: got %0d cycles timeout %b, required %0d", busyCnt, to, 2 * (8 + PROG));
    end
    tests++;
    if (wrQ.size() != 0 || Level !== 5'd0) begin
      failed++; $display("FAIL write2_done: got %0d writes pending level %0d, required 0/0", wrQ.size(), Level);
    end
    // Pointer must have advanced to base+count.
    rdQ.push_back(16'h1236);
    step(1'b1, 1'b1, 1'b0);
    sendByte(8'hA1, en);
    readByte(1'b1, b, en);
    tests++;
    if (b !== flashByte(16'h1236) || !en) begin
      failed++; $display("FAIL ptr_after_flush: got data %h en %b, required %h en 1", b, en, flashByte(16'h1236));
    end
    tests++;
    if (rdQ.size() != 0) begin
      failed++; $display("FAIL ptr_after_flush_read: got %0d reads missing, required 0", rdQ.size());
    end
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_page_full;
    logic [31:0] acks;
    logic        to;
    for (int i = 0; i < 17; i++) txData[i] = 8'hC0 + 8'(i);
    writeTxn(16'h0010, 17, acks);
    tests++;
    if (acks[19:0] !== 20'h7FFFF) begin
      failed++; $display("FAIL page_full_acks: got %h, required 7ffff", acks[19:0]);
    end
    tests++;
    if (Level !== 5'd16) begin
      failed++; $display("FAIL page_full_level: got %0d, required 16", Level);
    end
    pushProgram(16'h0010, 16);
    busyCnt = 0;
    step(1'b1, 1'b0, 1'b1);
    waitIdle(400, to);
    tests++;
    if (to || busyCnt != 16 * (8 + PROG) || wrQ.size() != 0) begin
      failed++; $display("FAIL page_full_flush: got %0d cycles %0d pending, required %0d cycles 0 pending",
                         busyCnt, wrQ.size(), 16 * (8 + PROG));
    end
  endtask

  task automatic test_seq_read;
    logic [31:0] acks;
    logic        k, en;
    logic [7:0]  b, e;
    logic        anyEn;
    writeTxn(16'hFFFE, 0, acks);
    rdQ.push_back(16'hFFFE); rdQ.push_back(16'hFFFF); rdQ.push_back(16'h0000);
    rdDataQ.push_back(8'h5A); rdDataQ.push_back(8'h6B); rdDataQ.push_back(8'h7C);
    step(1'b1, 1'b1, 1'b0);
    sendByte(8'hA1, k);
    tests++;
    if ({acks[2:0], k} !== 4'b1111) begin
      failed++; $display("FAIL read_setup_acks: got %b, required 1111", {acks[2:0], k});
    end
    for (int i = 0; i < 3; i++) begin
      readByte(i == 2, b, en);
      e = rdDataQ.pop_front();
      tests++;
      if (b !== e || !en) begin
        failed++; $display("FAIL read_byte%0d: got %h en %b, required %h en 1", i, b, en, e);
      end
    end
    // After the NACK the slave must stay off the bus.
    anyEn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0);
      anyEn = anyEn | obsEn;
    end
    tests++;
    if (anyEn !== 1'b0 || rdQ.size() != 0) begin
      failed++; $display("FAIL read_idle: got sda_en %b reads pending %0d, required 0/0", anyEn, rdQ.size());
    end
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_bad_id_and_busy;
    logic        k, to;
    logic [31:0] acks;
    step(1'b1, 1'b1, 1'b0);
    sendByte(8'hB0, k);
    busyCnt = 0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    tests++;
    if (k !== 1'b0 || busyCnt != 0) begin
      failed++; $display("FAIL bad_id: got ack %b busy %0d, required 0/0", k, busyCnt);
    end
    txData[0] = 8'h5C;
    writeTxn(16'h0200, 1, acks);
    pushProgram(16'h0200, 1);
    busyCnt = 0;
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    sendByte(8'hA0, k);
    tests++;
    if (k !== 1'b0) begin
      failed++; $display("FAIL busy_id_nack: got ack %b, required 0", k);
    end
    waitIdle(200, to);
    tests++;
    if (to || busyCnt != 8 + PROG || wrQ.size() != 0) begin
      failed++; $display("FAIL busy_flush: got %0d cycles %0d pending, required %0d cycles 0 pending",
                         busyCnt, wrQ.size(), 8 + PROG);
    end
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_flush;
    logic [31:0] acks;
    logic        to;
    txData[0] = 8'h77;
    writeTxn(16'h0300, 1, acks);
    step(1'b1, 1'b0, 1'b1);
    tests++;
    if (WEbar !== 1'b0 || Busy !== 1'b1) begin
      failed++; $display("FAIL pre_reset_flush: got webar %b busy %b, required 0/1", WEbar, Busy);
    end
    RESET = 1'b1;
    #1;
    tests++;
    if ({WEbar, ENbar, Busy, EnIOOut, Level} !== {4'b1100, 5'd0}) begin
      failed++; $display("FAIL async_reset: got webar %b enbar %b busy %b enio %b level %0d, required 1 1 0 0 0",
                         WEbar, ENbar, Busy, EnIOOut, Level);
    end
    #2;
    RESET = 1'b0;
    txData[0] = 8'h99;
    writeTxn(16'h0040, 1, acks);
    tests++;
    if (acks[3:0] !== 4'b1111) begin
      failed++; $display("FAIL post_reset_acks: got %b, required 1111", acks[3:0]);
    end
    pushProgram(16'h0040, 1);
    busyCnt = 0;
    step(1'b1, 1'b0, 1'b1);
    waitIdle(200, to);
    tests++;
    if (to || busyCnt != 8 + PROG || wrQ.size() != 0) begin
      failed++; $display("FAIL post_reset_flush: got %0d cycles %0d pending, required %0d cycles 0 pending",
                         busyCnt, wrQ.size(), 8 + PROG);
    end
  endtask

  task automatic test_partial_byte;
    logic [31:0] acks;
    logic        to;
    txData[0] = 8'h33;
    writeTxn(16'h0080, 1, acks);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (Level !== 5'd1) begin
      failed++; $display("FAIL partial_level: got %0d, required 1", Level);
    end
    pushProgram(16'h0080, 1);
    busyCnt = 0;
    step(1'b1, 1'b0, 1'b1);
    waitIdle(200, to);
    tests++;
    if (to || busyCnt != 8 + PROG || wrQ.size() != 0) begin
      failed++; $display("FAIL partial_flush: got %0d cycles %0d pending, required %0d cycles 0 pending",
                         busyCnt, wrQ.size(), 8 + PROG);
    end
  endtask

  initial begin
    test_reset;
    test_write_two;
    test_page_full;
    test_seq_read;
    test_bad_id_and_busy;
    test_reset_mid_flush;
    test_partial_byte;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
